// File: rtl/stpmtr_pkg.sv
// ---------------------------------------------------------------------------
// stpmtr_pkg
// Shared definitions for the stepper-motor phase sequencer:
//   - state_t     : sequencer FSM encoding (IDLE / RUN / DONE)
//   - PHASE_TABLE : 8-entry coil pattern table, entry n in bits [4n+3:4n]
//   - phase_of()  : idx[2:0] -> coil[3:0] lookup into PHASE_TABLE
// Coil bit order everywhere is {A,B,C,D}.
// ---------------------------------------------------------------------------
package stpmtr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Even entries energise one coil (wave drive), odd entries energise two
  // adjacent coils (two-phase drive). Full-step moves by 2 keep the parity.
  localparam logic [31:0] PHASE_TABLE = {
    4'b1001,  // idx 7
    4'b0001,  // idx 6
    4'b0011,  // idx 5
    4'b0010,  // idx 4
    4'b0110,  // idx 3
    4'b0100,  // idx 2
    4'b1100,  // idx 1
    4'b1000   // idx 0
  };

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/stpmtr_phase.sv
// ---------------------------------------------------------------------------
// stpmtr_phase
// Purely combinational phase lookup: sequence index -> coil pattern.
// Ports:
//   i_idx   in  3  sequence index 0..7
//   o_coil  out 4  coil pattern {A,B,C,D} for that index
// ---------------------------------------------------------------------------
module stpmtr_phase
  import stpmtr_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [3:0] o_coil
);

  always_comb begin
    o_coil = phase_of(i_idx);
  end

endmodule

// File: rtl/stpmtr_seq.sv
// ---------------------------------------------------------------------------
// stpmtr_seq
// Stepper-motor phase sequencer. One motor step per rising edge of rate_i
// (the clkgen output, already synchronous to clk_i). Accepts a move command
// (step count, direction, full/half step), walks the 8-entry phase table and
// tracks the net signed position.
//
// Command handshake: a command transfers on a clk_i edge where
// cmd_valid_i & cmd_ready_o are both high. cmd_ready_o is high only in IDLE;
// cmd_valid_i may stay high, nothing is queued, and the command fields are
// sampled only in the transfer cycle.
//
// Ports:
//   clk_i        in   1      system clock
//   rst_i        in   1      synchronous reset, active-high
//   rate_i       in   1      step-rate clock from clkgen
//   cmd_valid_i  in   1      command valid
//   cmd_ready_o  out  1      command ready (IDLE only)
//   cmd_steps_i  in   STEPW  steps to move
//   cmd_dir_i    in   1      1 = forward, 0 = reverse
//   cmd_half_i   in   1      1 = half-step, 0 = full-step
//   abort_i      in   1      end the current move at the next clock
//   coil_o       out  4      registered coil drive {A,B,C,D}
//   busy_o       out  1      high in RUN
//   done_o       out  1      one-cycle pulse when a move ends
//   pos_o        out  POSW   net signed step count since reset (wraps)
//   dbg_state_o  out  2      current FSM state
// ---------------------------------------------------------------------------
module stpmtr_seq
  import stpmtr_pkg::*;
#(
  parameter int STEPW = 16,
  parameter int POSW  = 16,
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rate_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [STEPW-1:0] cmd_steps_i,
  input  logic             cmd_dir_i,
  input  logic             cmd_half_i,
  input  logic             abort_i,
  output logic [3:0]       coil_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [POSW-1:0]  pos_o,
  output state_t           dbg_state_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rate_q;
  logic [2:0]       r_idx;
  logic [STEPW-1:0] r_remaining;
  logic [POSW-1:0]  r_pos;
  logic             r_dir;
  logic             r_half;
  logic [3:0]       r_coil;

  logic             w_tick;
  logic             w_accept;
  logic             w_abort;
  logic             w_step;
  logic [2:0]       w_delta;
  logic [3:0]       w_phase;

  // rate_i comes from clkgen on the same clock, so one register is enough
  // for edge detection; no synchroniser.
  assign w_tick   = rate_i & ~r_rate_q;
  assign w_accept = cmd_valid_i & (r_state == ST_IDLE);
  assign w_abort  = abort_i & (r_state == ST_RUN);
  // Abort beats a coincident tick: no step is taken in that cycle.
  assign w_step   = (r_state == ST_RUN) & w_tick & ~abort_i;
  assign w_delta  = r_half ? 3'd1 : 3'd2;

  stpmtr_phase u_phase (
    .i_idx  (r_idx),
    .o_coil (w_phase)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (cmd_steps_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          w_state_nxt = ST_DONE;
        end else if (w_tick && (r_remaining == STEPW'(1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready_o = (r_state == ST_IDLE);
    busy_o      = (r_state == ST_RUN);
    done_o      = (r_state == ST_DONE);
    dbg_state_o = r_state;
    coil_o      = r_coil;
    pos_o       = r_pos;
  end

  // Datapath: edge detector, command latch, index/position/remaining, coil.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rate_q    <= 1'b0;
      r_idx       <= 3'd0;
      r_remaining <= '0;
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_half      <= 1'b0;
      r_coil      <= HOLD ? phase_of(3'd0) : 4'b0000;
    end else begin
      r_rate_q <= rate_i;

      if (w_accept) begin
        r_dir       <= cmd_dir_i;
        r_half      <= cmd_half_i;
        r_remaining <= cmd_steps_i;
      end else if (w_abort) begin
        r_remaining <= '0;
      end else if (w_step) begin
        r_remaining <= r_remaining - STEPW'(1);
        r_idx       <= r_dir ? (r_idx + w_delta) : (r_idx - w_delta);
        r_pos       <= r_dir ? (r_pos + POSW'(1)) : (r_pos - POSW'(1));
      end

      // Coil follows the index one cycle later; with HOLD=0 it drops to
      // zero once the sequencer has returned to IDLE.
      if (HOLD || (r_state != ST_IDLE)) begin
        r_coil <= w_phase;
      end else begin
        r_coil <= 4'b0000;
      end
    end
  end

endmodule
